// File: rtl/ahb_crc_pkg.sv
// Shared constants, register map and engine states for the AHB CRC slave.
// Build option CRC_REFLECT_EN enables the byte/result bit-reversal helpers' use.
package ahb_crc_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // word index, i.e. HADDR[4:2]
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_POLY   = 3'd1;
  localparam logic [2:0] REG_INIT   = 3'd2;
  localparam logic [2:0] REG_DATA   = 3'd3;
  localparam logic [2:0] REG_RESULT = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  localparam int CTRL_START   = 0;
  localparam int CTRL_XOROUT  = 1;
  localparam int CTRL_REFLECT = 2;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_ERR     = 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } eng_state_e;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = w[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// One byte of a 32-bit MSB-first CRC: eight LFSR shifts with a
// programmable polynomial, fully combinational.
module crc_byte_step (
  input  logic [31:0] crc_in,
  input  logic [31:0] poly,
  input  logic [7:0]  byte_in,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (crc_out[31] ^ byte_in[i])
        crc_out = {crc_out[30:0], 1'b0} ^ poly;
      else
        crc_out = {crc_out[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/ahb_crc_slave.sv
// AHB slave wrapping a byte-serial programmable CRC-32 engine.
// Define CRC_REFLECT_EN for CTRL.REFLECT (input byte and result reversal).
module ahb_crc_slave
  import ahb_crc_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] POLY_RST   = 32'h04C11DB7,
  parameter logic [31:0] INIT_RST   = 32'hFFFFFFFF
) (
  input  logic                  HCLK,
  input  logic                  RESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic                  HMASTLOCK,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADY,
  output logic                  HRESP
);

  logic        dp_q, dp_d;
  logic        dwr_q, dwr_d;
  logic [2:0]  dreg_q, dreg_d;
  logic [2:0]  dsize_q, dsize_d;
  logic        err1_q, err1_d;
  logic        err2_q, err2_d;
  logic        errf_q, errf_d;
  logic        xorout_q, xorout_d;
  logic [31:0] poly_q, poly_d;
  logic [31:0] init_q, init_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] buf_q, buf_d;
  logic [1:0]  cnt_q, cnt_d;
  eng_state_e  state_q, state_d;
`ifdef CRC_REFLECT_EN
  logic        reflect_q, reflect_d;
`endif

  logic        busy, stall_reg, stall;
  logic        done, wr_done, accept, bad;
  logic [2:0]  a_reg;
  logic [7:0]  step_byte;
  logic [31:0] step_crc, result, rdata;
  logic        unused_ok;

  assign unused_ok = ^{HBURST, HMASTLOCK, HTRANS[0],
                       HADDR[ADDR_WIDTH-1:5]};

  assign a_reg     = HADDR[4:2];
  assign busy      = (state_q == SHIFT);
  // writes that touch engine state and RESULT reads wait for it to drain
  assign stall_reg = dwr_q ? (dreg_q <= REG_DATA)
                           : (dreg_q == REG_RESULT);
  assign stall     = dp_q & busy & stall_reg;
  assign HREADY    = ~stall & ~err1_q;
  assign HRESP     = err1_q | err2_q;
  assign done      = dp_q & ~stall;
  assign wr_done   = done & dwr_q;
  assign accept    = HSEL & HTRANS[1] & HREADY;

  assign bad = (a_reg > REG_STATUS)
             | (HWRITE & (a_reg == REG_RESULT))
             | (HSIZE > HSIZE_WORD)
             | ((a_reg == REG_DATA) & (HADDR[1:0] != 2'b00));

`ifdef CRC_REFLECT_EN
  assign step_byte = reflect_q ? rev8(buf_q[31:24]) : buf_q[31:24];
`else
  assign step_byte = buf_q[31:24];
`endif

  crc_byte_step u_step (
    .crc_in  (crc_q),
    .poly    (poly_q),
    .byte_in (step_byte),
    .crc_out (step_crc)
  );

  always_comb begin
    dp_d     = dp_q;
    dwr_d    = dwr_q;
    dreg_d   = dreg_q;
    dsize_d  = dsize_q;
    err1_d   = accept & bad;
    err2_d   = err1_q;
    errf_d   = errf_q;
    xorout_d = xorout_q;
    poly_d   = poly_q;
    init_d   = init_q;
    crc_d    = crc_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
`ifdef CRC_REFLECT_EN
    reflect_d = reflect_q;
`endif
    if (HREADY) begin
      dp_d    = accept & ~bad;
      dwr_d   = HWRITE;
      dreg_d  = a_reg;
      dsize_d = HSIZE;
    end
    if (wr_done) begin
      unique case (1'b1)
        dreg_q == REG_CTRL: begin
          xorout_d = HWDATA[CTRL_XOROUT];
`ifdef CRC_REFLECT_EN
          reflect_d = HWDATA[CTRL_REFLECT];
`endif
          if (HWDATA[CTRL_START]) crc_d = init_q;
        end
        dreg_q == REG_POLY: poly_d = HWDATA;
        dreg_q == REG_INIT: init_d = HWDATA;
        dreg_q == REG_DATA: begin
          state_d = SHIFT;
          unique case (1'b1)
            dsize_q == HSIZE_BYTE: begin
              buf_d = {HWDATA[7:0], 24'h0};
              cnt_d = 2'd0;
            end
            dsize_q == HSIZE_HALF: begin
              buf_d = {HWDATA[15:0], 16'h0};
              cnt_d = 2'd1;
            end
            default: begin
              buf_d = HWDATA;
              cnt_d = 2'd3;
            end
          endcase
        end
        dreg_q == REG_STATUS: begin
          if (HWDATA[STAT_ERR]) errf_d = 1'b0;
        end
        default: ;
      endcase
    end
    if (accept & bad) errf_d = 1'b1;
    if (busy) begin
      crc_d = step_crc;
      buf_d = {buf_q[23:0], 8'h00};
      if (cnt_q == 2'd0) state_d = IDLE;
      else cnt_d = cnt_q - 2'd1;
    end
  end

  always_comb begin
    result = crc_q;
`ifdef CRC_REFLECT_EN
    if (reflect_q) result = rev32(crc_q);
`endif
    if (xorout_q) result = ~result;
    rdata = '0;
    unique case (1'b1)
      dreg_q == REG_CTRL: begin
        rdata[CTRL_XOROUT] = xorout_q;
`ifdef CRC_REFLECT_EN
        rdata[CTRL_REFLECT] = reflect_q;
`endif
      end
      dreg_q == REG_POLY:   rdata = poly_q;
      dreg_q == REG_INIT:   rdata = init_q;
      dreg_q == REG_RESULT: rdata = result;
      dreg_q == REG_STATUS: begin
        rdata[STAT_BUSY] = busy;
        rdata[STAT_ERR]  = errf_q;
      end
      default: ;
    endcase
  end

  assign HRDATA = (dp_q & ~dwr_q) ? rdata : '0;

  always_ff @(posedge HCLK or posedge RESET) begin
    if (RESET) begin
      dp_q     <= 1'b0;
      dwr_q    <= 1'b0;
      dreg_q   <= 3'd0;
      dsize_q  <= 3'd0;
      err1_q   <= 1'b0;
      err2_q   <= 1'b0;
      errf_q   <= 1'b0;
      xorout_q <= 1'b0;
      poly_q   <= POLY_RST;
      init_q   <= INIT_RST;
      crc_q    <= INIT_RST;
      buf_q    <= 32'h0;
      cnt_q    <= 2'd0;
      state_q  <= IDLE;
`ifdef CRC_REFLECT_EN
      reflect_q <= 1'b0;
`endif
    end else begin
      dp_q     <= dp_d;
      dwr_q    <= dwr_d;
      dreg_q   <= dreg_d;
      dsize_q  <= dsize_d;
      err1_q   <= err1_d;
      err2_q   <= err2_d;
      errf_q   <= errf_d;
      xorout_q <= xorout_d;
      poly_q   <= poly_d;
      init_q   <= init_d;
      crc_q    <= crc_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
`ifdef CRC_REFLECT_EN
      reflect_q <= reflect_d;
`endif
    end
  end

endmodule

// File: tb/tb_ahb_crc_slave.sv
// Randomized self-checking bench for ahb_crc_slave against a
// byte-queue CRC reference model.
module tb_ahb_crc_slave;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_POLY   = 32'h04;
  localparam logic [31:0] A_INIT   = 32'h08;
  localparam logic [31:0] A_DATA   = 32'h0C;
  localparam logic [31:0] A_RESULT = 32'h10;
  localparam logic [31:0] A_STATUS = 32'h14;
  localparam logic [2:0]  SZ_B = 3'd0;
  localparam logic [2:0]  SZ_H = 3'd1;
  localparam logic [2:0]  SZ_W = 3'd2;
  localparam int          LIMIT = 40;

  logic        HCLK = 1'b0;
  logic        RESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  always #5 HCLK = ~HCLK;

  ahb_crc_slave dut (
    .HCLK      (HCLK),
    .RESET     (RESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HMASTLOCK (HMASTLOCK),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // reference model
  logic [31:0] m_poly, m_init, m_crc;
  logic        m_xo, m_rf;

  function automatic logic [31:0] feed(input logic [31:0] c,
    input logic [31:0] p, input logic [7:0] b, input logic rf);
    logic [7:0] x;
    x = b;
    if (rf) for (int i = 0; i < 8; i++) x[i] = b[7-i];
    c = c ^ {x, 24'h0};
    for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ p) : (c << 1);
    return c;
  endfunction

  function automatic logic [31:0] exp_result();
    logic [31:0] r;
    r = m_crc;
    if (m_rf) for (int i = 0; i < 32; i++) r[i] = m_crc[31-i];
    return m_xo ? (r ^ 32'hFFFFFFFF) : r;
  endfunction

  task automatic model_data(input logic [31:0] d, input logic [2:0] s);
    int n;
    n = (s == SZ_B) ? 1 : (s == SZ_H) ? 2 : 4;
    for (int i = n - 1; i >= 0; i--)
      m_crc = feed(m_crc, m_poly, d[8*i +: 8], m_rf);
  endtask

  task automatic model_ctrl(input logic [31:0] d);
    m_xo = d[1];
`ifdef CRC_REFLECT_EN
    m_rf = d[2];
`else
    m_rf = 1'b0;
`endif
    if (d[0]) m_crc = m_init;
  endtask

  // bus master
  logic [31:0] rdv;
  logic        rsp, rsp0;
  int          st;

  task automatic bus_idle();
    HSEL = 1'b0;
    HTRANS = 2'b00;
    HADDR = 32'h0;
    HWRITE = 1'b0;
    HSIZE = SZ_W;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (HREADY !== 1'b1 && n < LIMIT) begin
      n++;
      @(negedge HCLK);
    end
    if (n >= LIMIT) check("hready_timeout", 32'(n), 32'd0);
  endtask

  // one transfer, next address phase only after this one completes
  task automatic xfer(input logic wr, input logic [31:0] a,
                      input logic [2:0] s, input logic [31:0] d);
    HSEL = 1'b1;
    HTRANS = 2'b10;
    HADDR = a;
    HWRITE = wr;
    HSIZE = s;
    HBURST = 3'($urandom_range(0, 7));
    @(negedge HCLK);
    bus_idle();
    HWDATA = d;
    rsp0 = HRESP;
    wait_ready(st);
    rdv = HRDATA;
    rsp = HRESP;
    @(negedge HCLK);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [2:0] s);
    xfer(1'b1, a, s, d);
  endtask

  task automatic rd(input logic [31:0] a);
    xfer(1'b0, a, SZ_W, 32'h0);
  endtask

  // write with a RESULT read pipelined into its data phase
  task automatic wr_rd(input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] s, output int wst,
                       output int rst_n, output logic [31:0] rdat);
    HSEL = 1'b1;
    HTRANS = 2'b10;
    HADDR = a;
    HWRITE = 1'b1;
    HSIZE = s;
    @(negedge HCLK);
    HWDATA = d;
    HADDR = A_RESULT;
    HWRITE = 1'b0;
    HSIZE = SZ_W;
    wait_ready(wst);
    @(negedge HCLK);
    bus_idle();
    wait_ready(rst_n);
    rdat = HRDATA;
    @(negedge HCLK);
  endtask

  task automatic digits(input logic [31:0] ctrl,
                        input logic [31:0] exp, input string tag);
    wr(A_CTRL, ctrl, SZ_W);
    for (int i = 0; i < 9; i++)
      wr(A_DATA, ($urandom() & 32'hFFFFFF00) | (32'h31 + i), SZ_B);
    rd(A_RESULT);
    check(tag, rdv, exp);
  endtask

  task automatic expect_err(input string tag);
    check({tag, "_wait"}, 32'(st), 32'd1);
    check({tag, "_resp0"}, 32'(rsp0), 32'd1);
    check({tag, "_resp1"}, 32'(rsp), 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int wst, rst2;
    logic [31:0] rdat, d;
    logic [2:0]  s;
    logic [31:0] ctrl_exp;

    bus_idle();
    HBURST = 3'd0;
    HMASTLOCK = 1'b0;
    HWDATA = 32'h0;
    RESET = 1'b1;
    repeat (2) @(negedge HCLK);
    check("rst_hready", 32'(HREADY), 32'd1);
    check("rst_hresp", 32'(HRESP), 32'd0);
    check("rst_hrdata", HRDATA, 32'h0);
    RESET = 1'b0;
    @(negedge HCLK);

    rd(A_POLY);
    check("rst_poly", rdv, 32'h04C11DB7);
    check("rst_poly_wait", 32'(st), 32'd0);
    check("rst_poly_resp", 32'(rsp), 32'd0);
    rd(A_INIT);
    check("rst_init", rdv, 32'hFFFFFFFF);
    check("rst_init_wait", 32'(st), 32'd0);
    rd(A_RESULT);
    check("rst_result", rdv, 32'hFFFFFFFF);
    check("rst_result_wait", 32'(st), 32'd0);
    rd(A_CTRL);
    check("rst_ctrl", rdv, 32'h0);
    rd(A_STATUS);
    check("rst_status", rdv, 32'h0);

    digits(32'h3, 32'hFC891918, "crc_bzip2");
    digits(32'h1, 32'h0376E6E7, "crc_mpeg2");

    wr(A_CTRL, 32'h3, SZ_W);
    wr(A_DATA, 32'h31323334, SZ_W);
    check("word1_wait", 32'(st), 32'd0);
    wr(A_DATA, 32'h35363738, SZ_W);
    check("word2_wait", 32'(st), 32'd3);
    wr_rd(A_DATA, 32'hA5A5A539, SZ_B, wst, rst2, rdat);
    check("byte_wait", 32'(wst), 32'd3);
    check("res_read_wait", 32'(rst2), 32'd1);
    check("crc_words", rdat, 32'hFC891918);

    rd(32'h18);
    expect_err("err_unmapped");
    wr(A_RESULT, 32'h12345678, SZ_W);
    expect_err("err_wr_result");
    wr(32'h0D, 32'h00000055, SZ_B);
    expect_err("err_data_misal");
    wr(A_POLY, 32'h12345678, 3'd3);
    expect_err("err_size");
    rd(A_POLY);
    check("poly_kept", rdv, 32'h04C11DB7);
    rd(A_RESULT);
    check("crc_kept", rdv, 32'hFC891918);
    rd(A_STATUS);
    check("err_sticky", rdv, 32'h2);
    wr(A_STATUS, 32'h2, SZ_W);
    rd(A_STATUS);
    check("err_cleared", rdv, 32'h0);

    wr(A_CTRL, 32'h7, SZ_W);
    rd(A_CTRL);
`ifdef CRC_REFLECT_EN
    check("ctrl_reflect", rdv, 32'h6);
    digits(32'h7, 32'hCBF43926, "crc_32");
`else
    check("ctrl_reflect", rdv, 32'h2);
`endif

    m_poly = 32'h04C11DB7;
    m_init = $urandom();
    wr(A_POLY, m_poly, SZ_W);
    wr(A_INIT, m_init, SZ_W);
    d = {29'h0, 3'($urandom_range(0, 7))} | 32'h1;
    wr(A_CTRL, d, SZ_W);
    model_ctrl(d);
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0: begin
          m_poly = $urandom();
          wr(A_POLY, m_poly, SZ_W);
        end
        1: begin
          m_init = $urandom();
          wr(A_INIT, m_init, SZ_W);
        end
        2: begin
          d = $urandom();
          wr(A_CTRL, d, SZ_W);
          model_ctrl(d);
        end
        3, 4, 5, 6: begin
          d = $urandom();
          s = 3'($urandom_range(0, 2));
          model_data(d, s);
          if ($urandom_range(0, 1) == 1) begin
            wr_rd(A_DATA, d, s, wst, rst2, rdat);
            check("rnd_pipe_result", rdat, exp_result());
          end else begin
            wr(A_DATA, d, s);
          end
        end
        7, 8: begin
          rd(A_RESULT);
          check("rnd_result", rdv, exp_result());
        end
        default: begin
          rd(A_CTRL);
          ctrl_exp = {29'h0, m_rf, m_xo, 1'b0};
          check("rnd_ctrl", rdv, ctrl_exp);
          rd(A_POLY);
          check("rnd_poly", rdv, m_poly);
          rd(A_INIT);
          check("rnd_init", rdv, m_init);
        end
      endcase
    end
    rd(A_RESULT);
    check("rnd_final", rdv, exp_result());

    wr(A_DATA, $urandom(), SZ_W);
    rd(A_STATUS);
    check("busy_mid", 32'(rdv[0]), 32'd1);
    RESET = 1'b1;
    @(negedge HCLK);
    RESET = 1'b0;
    @(negedge HCLK);
    rd(A_RESULT);
    check("reset_mid_result", rdv, 32'hFFFFFFFF);
    check("reset_mid_wait", 32'(st), 32'd0);
    rd(A_STATUS);
    check("reset_mid_status", rdv, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
